// File: rtl/seq_pkg.sv
// Shared encodings for the 1011 detector front end: serializer FSM codes,
// counter widths and the detector's own state codes.
package seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_PAR   = ST_PAR,
    S_GAP   = ST_GAP
  } ser_state_t;

  // Gap counter covers IDLE_BITS up to 15.
  localparam int GAP_CNT_W = 4;

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  localparam logic [2:0] DET_IDLE = 3'd0;
  localparam logic [2:0] DET_1    = 3'd1;
  localparam logic [2:0] DET_10   = 3'd2;
  localparam logic [2:0] DET_101  = 3'd3;
  localparam logic [2:0] DET_1011 = 3'd4;

  typedef enum logic [2:0] {
    D_IDLE = DET_IDLE,
    D_1    = DET_1,
    D_10   = DET_10,
    D_101  = DET_101,
    D_1011 = DET_1011
  } det_state_t;

endpackage

// File: rtl/ser_hold_buf.sv
// Single-entry valid/ready hold register in front of the serializer shifter.
// in_ready is taken straight from the full flag, so a draining edge never accepts.
module ser_hold_buf
  import seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] buf_data,
  output logic              buf_full
);

  assign in_ready = !buf_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (in_valid && in_ready) begin
      buf_full <= 1'b1;
      buf_data <= in_data;
    end else if (pop) begin
      buf_full <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-in/serial-out front end for the 1011 detector x input.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_BITS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_en,
  output logic              x,
  output logic              x_valid,
  output logic              word_start,
  output logic              busy
);

  localparam int                   CW       = bit_cnt_w(DATA_W);
  localparam logic [CW-1:0]        LAST_CNT = CW'(DATA_W);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(IDLE_BITS);
  localparam bit                   HAS_GAP  = (IDLE_BITS > 0);
  localparam bit                   MSBF     = (MSB_FIRST != 0);

  ser_state_t             state;
  logic [DATA_W-1:0]      shreg;
  logic [DATA_W-1:0]      buf_data;
  logic [CW-1:0]          bit_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic                   buf_full;
  logic                   decide;
  logic                   to_gap;
  logic                   load;
`ifdef SER_PARITY_EN
  logic                   par_q;
  logic                   to_par;
`endif

  ser_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pop      (load),
    .buf_data (buf_data),
    .buf_full (buf_full)
  );

  // decide marks the edge where the shifter is free: reload or fall back to idle.
  always_comb begin
    decide = 1'b0;
    to_gap = 1'b0;
`ifdef SER_PARITY_EN
    to_par = 1'b0;
`endif
    case (state)
      S_IDLE: decide = 1'b1;
      S_SHIFT: begin
        if (bit_cnt == LAST_CNT) begin
`ifdef SER_PARITY_EN
          to_par = 1'b1;
`else
          if (HAS_GAP) to_gap = 1'b1;
          else         decide = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      S_PAR: begin
        if (HAS_GAP) to_gap = 1'b1;
        else         decide = 1'b1;
      end
`endif
      S_GAP: begin
        if (gap_cnt == GAP_LAST) decide = 1'b1;
      end
      default: decide = 1'b1;
    endcase
  end

  assign load = bit_en && buf_full && decide;
  assign busy = buf_full || (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      x          <= 1'b0;
      x_valid    <= 1'b0;
      word_start <= 1'b0;
`ifdef SER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else if (!bit_en) begin
      x_valid    <= 1'b0;
      word_start <= 1'b0;
    end else begin
      x_valid    <= 1'b1;
      word_start <= 1'b0;
      if (load) begin
        state      <= S_SHIFT;
        bit_cnt    <= CW'(1);
        word_start <= 1'b1;
        x          <= MSBF ? buf_data[DATA_W-1] : buf_data[0];
        shreg      <= MSBF ? (buf_data << 1) : (buf_data >> 1);
`ifdef SER_PARITY_EN
        par_q      <= ^buf_data;
`endif
      end else if (decide) begin
        state   <= S_IDLE;
        x_valid <= 1'b0;
`ifdef SER_PARITY_EN
      end else if (to_par) begin
        state <= S_PAR;
        x     <= par_q;
`endif
      end else if (to_gap) begin
        state   <= S_GAP;
        gap_cnt <= GAP_CNT_W'(1);
        x       <= 1'b0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
        x       <= 1'b0;
      end else begin
        x       <= MSBF ? shreg[DATA_W-1] : shreg[0];
        shreg   <= MSBF ? (shreg << 1) : (shreg >> 1);
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
